// File: rtl/keygen_pkg.sv
// keygen_pkg: shared types and constants for the key-exponent generator.
// Holds the controller state enum, the Galois LFSR tap mask and the default seed.
package keygen_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRAW      = 3'd1,
        RANGE     = 3'd2,
        GCD_START = 3'd3,
        GCD_WAIT  = 3'd4,
        CHECK     = 3'd5,
        DONE      = 3'd6,
        FAIL      = 3'd7
    } state_t;

    // x^32 + x^22 + x^2 + x + 1 as a right-shifting Galois tap mask
    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_LFSR_SEED = 32'hACE1_0001;

endpackage

// File: rtl/keygen_if.sv
// keygen_if: request/response bundle between a host and keygen_ctrl.
// The host drives through the master modport; the controller uses the slave modport.
interface keygen_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] phi_in;
    logic             seed_ld;
    logic [WIDTH-1:0] seed_in;
    logic             busy;
    logic             done;
    logic             fail;
    logic [WIDTH-1:0] public_key;
    logic [WIDTH-1:0] gcd_out;

    modport master (
        output start, phi_in, seed_ld, seed_in,
        input  busy, done, fail, public_key, gcd_out
    );

    modport slave (
        input  start, phi_in, seed_ld, seed_in,
        output busy, done, fail, public_key, gcd_out
    );
endinterface

// File: rtl/gcd_core.sv
// gcd_core: iterative Euclid engine, one remainder step per clock.
// A start pulse loads (a, b); done pulses for one cycle with result once b reaches 0.
module gcd_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             running;

    // Load operands on start, then step (a, b) -> (b, a mod b) until b is zero
    always_ff @(posedge clk) begin
        if (rst) begin
            ra      <= '0;
            rb      <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                ra      <= a;
                rb      <= b;
                running <= 1'b1;
            end else if (running) begin
                if (rb == '0) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                    result  <= ra;
                end else begin
                    ra <= rb;
                    rb <= ra % rb;
                end
            end
        end
    end

endmodule

// File: rtl/keygen_ctrl.sv
// keygen_ctrl: draws LFSR candidates until one is coprime to phi, or gives up
// after MAX_TRIES draws.
// Optional: define KEYGEN_TRIES_OUT_EN to expose the live draw count on port tries.
//
// state     | meaning
// IDLE      | waiting for start
// DRAW      | take LFSR value as candidate, advance LFSR, count the try
// RANGE     | require 1 < cand < phi
// GCD_START | kick gcd_core with (cand, phi)
// GCD_WAIT  | wait for gcd_core done
// CHECK     | register gcd; accept if 1, otherwise retry or give up
// DONE      | public_key valid, waiting for next start
// FAIL      | no usable candidate, waiting for next start
module keygen_ctrl
    import keygen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               MAX_TRIES = 16,
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(DEFAULT_LFSR_SEED)
) (
    input  logic       clk,
    input  logic       rst,
    keygen_if.slave    bus
`ifdef KEYGEN_TRIES_OUT_EN
    ,
    output logic [7:0] tries
`endif
);

    localparam logic [WIDTH-1:0] POLY      = WIDTH'(LFSR_POLY);
    localparam logic [7:0]       TRIES_MAX = 8'(MAX_TRIES);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] phi;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] public_key_q;
    logic [WIDTH-1:0] gcd_out_q;
    logic [7:0]       tries_q;

    logic             gcd_start;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;

    logic             ready;
    logic             accept;
    logic             phi_small;
    logic             in_range;
    logic             more_tries;
    logic             coprime;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    endfunction

    assign ready      = (state == IDLE) || (state == DONE) || (state == FAIL);
    assign accept     = ready && bus.start;
    assign phi_small  = phi < WIDTH'(3);
    assign in_range   = (cand > WIDTH'(1)) && (cand < phi);
    assign more_tries = tries_q < TRIES_MAX;
    assign coprime    = gcd_result == WIDTH'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and the gcd_core kick
    always_comb begin
        state_nxt = state;
        gcd_start = 1'b0;
        case (state)
            IDLE, DONE, FAIL: if (bus.start) state_nxt = DRAW;
            DRAW:             state_nxt = phi_small ? FAIL : RANGE;
            RANGE: begin
                if (in_range)        state_nxt = GCD_START;
                else if (more_tries) state_nxt = DRAW;
                else                 state_nxt = FAIL;
            end
            GCD_START: begin
                gcd_start = 1'b1;
                state_nxt = GCD_WAIT;
            end
            GCD_WAIT:         if (gcd_done) state_nxt = CHECK;
            CHECK: begin
                if (coprime)         state_nxt = DONE;
                else if (more_tries) state_nxt = DRAW;
                else                 state_nxt = FAIL;
            end
            default:          state_nxt = IDLE;
        endcase
    end

    // Datapath: seed load, request latch, candidate draw and result capture.
    // A seed load in the accepting cycle lands before DRAW reads the LFSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr         <= LFSR_SEED;
            phi          <= '0;
            cand         <= '0;
            tries_q      <= '0;
            public_key_q <= '0;
            gcd_out_q    <= '0;
        end else begin
            if (ready && bus.seed_ld)
                lfsr <= (bus.seed_in == '0) ? LFSR_SEED : bus.seed_in;
            if (accept) begin
                phi     <= bus.phi_in;
                tries_q <= '0;
            end
            if (state == DRAW && !phi_small) begin
                cand    <= lfsr;
                lfsr    <= lfsr_step(lfsr);
                tries_q <= tries_q + 8'd1;
            end
            if (state == CHECK) begin
                gcd_out_q <= gcd_result;
                if (coprime) public_key_q <= cand;
            end
        end
    end

    gcd_core #(.WIDTH(WIDTH)) u_gcd (
        .clk    (clk),
        .rst    (rst),
        .start  (gcd_start),
        .a      (cand),
        .b      (phi),
        .done   (gcd_done),
        .result (gcd_result)
    );

    assign bus.busy       = !ready;
    assign bus.done       = (state == DONE);
    assign bus.fail       = (state == FAIL);
    assign bus.public_key = public_key_q;
    assign bus.gcd_out    = gcd_out_q;

`ifdef KEYGEN_TRIES_OUT_EN
    assign tries = tries_q;
`endif

endmodule
